poly_eval: RTL and testbench

Parametrised polynomial evaluator: y = c[DEGREE]·x^DEGREE + … + c[1]·x + c[0], unsigned, evaluated by Horner's method on a single shared multiply/add datapath. Operands enter serially over one data port using a Go press/release handshake. The result is held in an output register. Sits behind the switch/key front end as the general-degree, general-width successor of the fixed quadratic datapath/control pair.

---
 rtl/poly_eval.sv | 158 +++++++++++++++
 tb/tb_poly_eval.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/poly_eval.sv
// Serial-load polynomial evaluator (Horner's method, one shared mul/add datapath).
// Define POLY_SATURATE_EN to clamp every multiply/add step at 2^WIDTH-1 instead of wrapping.
module poly_eval #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Go,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataResult,
    output logic             Done,
    output logic             Busy,
    output logic [3:0]       LoadIdx
);

    localparam logic [2:0] S_LOAD        = 3'd0;
    localparam logic [2:0] S_LOAD_WAIT   = 3'd1;
    localparam logic [2:0] S_LOAD_X      = 3'd2;
    localparam logic [2:0] S_LOAD_X_WAIT = 3'd3;
    localparam logic [2:0] S_MUL         = 3'd4;
    localparam logic [2:0] S_ADD         = 3'd5;

    localparam logic [3:0] K_TOP = 4'(DEGREE);

    logic [2:0]       state_q, state_d;
    logic [3:0]       k_q, k_d;
    logic [WIDTH-1:0] coef_q [DEGREE+1];
    logic [WIDTH-1:0] coef_d [DEGREE+1];
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] coef_sel;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] add_res;

    always_comb begin
        coef_sel = '0;
        for (int i = 0; i <= DEGREE; i++) begin
            if (k_q == 4'(i)) coef_sel = coef_q[i];
        end
    end

`ifdef POLY_SATURATE_EN
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    always_comb begin
        prod    = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
        sum     = {1'b0, acc_q} + {1'b0, coef_sel};
        mul_res = (|prod[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
        add_res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
`else
    always_comb begin
        mul_res = acc_q * x_q;
        add_res = acc_q + coef_sel;
    end
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        coef_d   = coef_q;
        x_d      = x_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (Go) begin
                    for (int i = 0; i <= DEGREE; i++) begin
                        if (k_q == 4'(i)) coef_d[i] = DataIn;
                    end
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (!Go) begin
                    if (k_q == 4'd0) begin
                        state_d = S_LOAD_X;
                    end else begin
                        k_d     = k_q - 4'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD_X: begin
                if (Go) begin
                    x_d     = DataIn;
                    state_d = S_LOAD_X_WAIT;
                end
            end
            S_LOAD_X_WAIT: begin
                // Horner seed: the leading coefficient is the initial accumulator.
                if (!Go) begin
                    acc_d   = coef_q[DEGREE];
                    k_d     = K_TOP - 4'd1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d   = mul_res;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (k_q != 4'd0) begin
                    acc_d   = add_res;
                    k_d     = k_q - 4'd1;
                    state_d = S_MUL;
                end else begin
                    result_d = add_res;
                    done_d   = 1'b1;
                    k_d      = K_TOP;
                    state_d  = S_LOAD;
                end
            end
            default: begin
                k_d     = K_TOP;
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_LOAD;
            k_q      <= K_TOP;
            x_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            for (int i = 0; i <= DEGREE; i++) coef_q[i] <= coef_d[i];
        end
    end

    always_comb begin
        Busy = (state_q == S_MUL) || (state_q == S_ADD);
        case (state_q)
            S_LOAD, S_LOAD_WAIT:     LoadIdx = k_q;
            S_LOAD_X, S_LOAD_X_WAIT: LoadIdx = 4'd15;
            default:                 LoadIdx = 4'd0;
        endcase
    end

    assign DataResult = result_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_poly_eval.sv
// Directed bench for poly_eval: an 8-bit degree-2 instance and a 16-bit degree-3 instance.
module tb_poly_eval;

    logic        Clock;
    logic        Resetn;
    logic        go_a, go_b;
    logic [7:0]  din_a;
    logic [15:0] din_b;
    logic [7:0]  res_a;
    logic [15:0] res_b;
    logic        done_a, done_b, busy_a, busy_b;
    logic [3:0]  idx_a, idx_b;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef POLY_SATURATE_EN
    localparam logic [7:0] EXP_OVF = 8'd255;
`else
    localparam logic [7:0] EXP_OVF = 8'd208;
`endif

    poly_eval #(.WIDTH(8), .DEGREE(2)) u_a (
        .Clock(Clock), .Resetn(Resetn), .Go(go_a), .DataIn(din_a),
        .DataResult(res_a), .Done(done_a), .Busy(busy_a), .LoadIdx(idx_a)
    );

    poly_eval #(.WIDTH(16), .DEGREE(3)) u_b (
        .Clock(Clock), .Resetn(Resetn), .Go(go_b), .DataIn(din_b),
        .DataResult(res_b), .Done(done_b), .Busy(busy_b), .LoadIdx(idx_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Loads c2,c1,c0,x into u_a; returns 1 time unit after E0.
    task automatic load_a(input logic [7:0] c2, input logic [7:0] c1,
                          input logic [7:0] c0, input logic [7:0] xv, input int hold);
        logic [7:0] ops [4];
        ops = '{c2, c1, c0, xv};
        for (int j = 0; j < 4; j++) begin
            go_a  = 1'b1;
            din_a = ops[j];
            repeat (hold) @(posedge Clock);
            #1 go_a = 1'b0;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        go_a = 1'b0; din_a = '0; go_b = 1'b0; din_b = '0;
        #12;
        n_chk++; if (res_a !== 8'd0) $display("FAIL reset_result act=%0d exp=0", res_a); else n_pass++;
        n_chk++; if (done_a !== 1'b0) $display("FAIL reset_done act=%b exp=0", done_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy act=%b exp=0", busy_a); else n_pass++;
        n_chk++; if (idx_a !== 4'd2) $display("FAIL reset_loadidx_a act=%0d exp=2", idx_a); else n_pass++;
        n_chk++; if (idx_b !== 4'd3) $display("FAIL reset_loadidx_b act=%0d exp=3", idx_b); else n_pass++;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_basic;
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        load_a(8'd3, 8'd2, 8'd1, 8'd4, 1);
        for (int i = 0; i < 7; i++) begin
            if (busy_a) busy_cnt++;
            if (done_a) begin done_cnt++; done_at = i; end
            if (i == 4) begin
                n_chk++; if (res_a !== 8'd57) $display("FAIL basic_result act=%0d exp=57", res_a); else n_pass++;
            end
            @(posedge Clock);
            #1;
        end
        n_chk++; if (busy_cnt !== 4) $display("FAIL basic_busy_cycles act=%0d exp=4", busy_cnt); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL basic_done_cycles act=%0d exp=1", done_cnt); else n_pass++;
        n_chk++; if (done_at !== 4) $display("FAIL basic_done_edge act=E0+%0d exp=E0+4", done_at); else n_pass++;
    endtask

    task automatic test_overflow;
        load_a(8'd20, 8'd0, 8'd0, 8'd10, 1);
        repeat (4) @(posedge Clock);
        #1;
        n_chk++; if (done_a !== 1'b1) $display("FAIL ovf_done act=%b exp=1", done_a); else n_pass++;
        n_chk++; if (res_a !== EXP_OVF) $display("FAIL ovf_result act=%0d exp=%0d", res_a, EXP_OVF); else n_pass++;
    endtask

    task automatic test_deg3;
        logic [15:0] ops  [5];
        logic [3:0]  idxs [5];
        ops  = '{16'd1, 16'd0, 16'd0, 16'd5, 16'd10};
        idxs = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
        for (int j = 0; j < 5; j++) begin
            n_chk++; if (idx_b !== idxs[j]) $display("FAIL deg3_loadidx%0d act=%0d exp=%0d", j, idx_b, idxs[j]); else n_pass++;
            go_b  = 1'b1;
            din_b = ops[j];
            @(posedge Clock);
            #1 go_b = 1'b0;
            @(posedge Clock);
            #1;
        end
        n_chk++; if (idx_b !== 4'd0) $display("FAIL deg3_loadidx_busy act=%0d exp=0", idx_b); else n_pass++;
        repeat (5) @(posedge Clock);
        #1;
        n_chk++; if (done_b !== 1'b0) $display("FAIL deg3_done_early act=%b exp=0", done_b); else n_pass++;
        @(posedge Clock);
        #1;
        n_chk++; if (done_b !== 1'b1) $display("FAIL deg3_done_e6 act=%b exp=1", done_b); else n_pass++;
        n_chk++; if (res_b !== 16'd1005) $display("FAIL deg3_result act=%0d exp=1005", res_b); else n_pass++;
    endtask

    task automatic test_long_go;
        load_a(8'd3, 8'd2, 8'd1, 8'd4, 5);
        go_a = 1'b1; din_a = 8'd99;
        @(posedge Clock); #1 go_a = 1'b0;
        @(posedge Clock); #1 go_a = 1'b1;
        @(posedge Clock); #1 go_a = 1'b0;
        @(posedge Clock); #1;
        n_chk++; if (done_a !== 1'b1) $display("FAIL longgo_done act=%b exp=1", done_a); else n_pass++;
        n_chk++; if (res_a !== 8'd57) $display("FAIL longgo_result act=%0d exp=57", res_a); else n_pass++;
        repeat (3) @(posedge Clock);
        #1;
        n_chk++; if (idx_a !== 4'd2) $display("FAIL longgo_no_extra_load act=%0d exp=2", idx_a); else n_pass++;
    endtask

    task automatic test_async_reset;
        load_a(8'd5, 8'd6, 8'd7, 8'd3, 1);
        @(posedge Clock);
        #3 Resetn = 1'b0;
        #1;
        n_chk++; if (res_a !== 8'd0) $display("FAIL arst_result act=%0d exp=0", res_a); else n_pass++;
        n_chk++; if (done_a !== 1'b0) $display("FAIL arst_done act=%b exp=0", done_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL arst_busy act=%b exp=0", busy_a); else n_pass++;
        n_chk++; if (idx_a !== 4'd2) $display("FAIL arst_loadidx act=%0d exp=2", idx_a); else n_pass++;
        n_chk++; if (res_b !== 16'd0) $display("FAIL arst_result_b act=%0d exp=0", res_b); else n_pass++;
        #2 Resetn = 1'b1;
        @(posedge Clock);
        #1;
        load_a(8'd1, 8'd1, 8'd1, 8'd2, 1);
        repeat (4) @(posedge Clock);
        #1;
        n_chk++; if (res_a !== 8'd7) $display("FAIL arst_rerun_result act=%0d exp=7", res_a); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int hold_bad;
        load_a(8'd3, 8'd2, 8'd1, 8'd4, 1);
        repeat (4) @(posedge Clock);
        #1;
        n_chk++; if (res_a !== 8'd57) $display("FAIL b2b_run1 act=%0d exp=57", res_a); else n_pass++;
        load_a(8'd0, 8'd0, 8'd9, 8'd200, 1);
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (res_a !== 8'd57) hold_bad++;
            @(posedge Clock);
            #1;
        end
        n_chk++; if (hold_bad !== 0 || res_a !== 8'd57) $display("FAIL b2b_hold act=%0d exp=57 bad=%0d", res_a, hold_bad); else n_pass++;
        @(posedge Clock);
        #1;
        n_chk++; if (done_a !== 1'b1) $display("FAIL b2b_done act=%b exp=1", done_a); else n_pass++;
        n_chk++; if (res_a !== 8'd9) $display("FAIL b2b_run2 act=%0d exp=9", res_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_deg3();
        test_long_go();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
